// File: rtl/audio_dac_serializer.sv
// Stereo PCM frame FIFO feeding an I2S / left-justified serial DAC link (bclk, lrclk, dac_data).
// Defining AUDIO_UNDERRUN_COUNT_EN adds a saturating 16-bit underrun_count output.
module audio_dac_serializer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int I2S_MODE     = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        mute,
    input  logic [SAMPLE_WIDTH-1:0]     in_left,
    input  logic [SAMPLE_WIDTH-1:0]     in_right,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        bclk,
    output logic                        lrclk,
    output logic                        dac_data,
    output logic                        underrun,
`ifdef AUDIO_UNDERRUN_COUNT_EN
    output logic [15:0]                 underrun_count,
`endif
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int CW         = $clog2(BCLK_DIV);
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int LW         = PW + 1;
    localparam int FW         = 2 * SAMPLE_WIDTH;
    localparam int IW         = $clog2(SAMPLE_WIDTH);

    logic [CW-1:0]           cnt, cnt_next;
    logic [BW-1:0]           b, b_next;
    logic                    run;
    logic                    tick, first, frame_end, pop, load;
    logic                    push, pop_ok, fifo_empty;
    logic [LW-1:0]           level_next;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [FW-1:0]           mem [FIFO_DEPTH];
    logic [FW-1:0]           head;
    logic [SAMPLE_WIDTH-1:0] cur_left, cur_right, new_left, new_right, sel;
    logic [IW-1:0]           idx;
    logic                    p_right, in_range, bit_val;
    int                      p, s, shamt;

    // Bit-clock divider and frame position; a pop happens on entry to b=0,
    // including the very first enabled cycle after an idle period.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
        tick      = enable && (cnt == CW'(BCLK_DIV - 1));
        first     = enable && !run;
        frame_end = (b == BW'(FRAME_BITS - 1));
        pop       = first || (tick && frame_end);
        load      = first || tick;
        cnt_next  = tick ? '0 : cnt + 1'b1;
        b_next    = b;
        if (tick) begin
            b_next = frame_end ? '0 : b + 1'b1;
        end
    end

    always_comb begin
        fifo_empty = (fifo_level == '0);
        push       = in_valid && in_ready;
        pop_ok     = pop && !fifo_empty;
        level_next = fifo_level;
        if (push && !pop_ok) begin
            level_next = fifo_level + 1'b1;
        end else if (!push && pop_ok) begin
            level_next = fifo_level - 1'b1;
        end
        head      = mem[rd_ptr];
        new_left  = pop_ok ? head[FW-1:SAMPLE_WIDTH] : '0;
        new_right = pop_ok ? head[SAMPLE_WIDTH-1:0] : '0;
    end

    // Serial bit for the slot position entering now. In I2S mode b=0 carries the
    // last right-slot bit, read from cur_right before the popped frame replaces it.
    always_comb begin
        p = int'(b_next);
        if (I2S_MODE != 0) begin
            p = (p == 0) ? FRAME_BITS - 1 : p - 1;
        end
        p_right  = (p >= SLOT_WIDTH);
        s        = p_right ? p - SLOT_WIDTH : p;
        in_range = (s < SAMPLE_WIDTH);
        shamt    = in_range ? SAMPLE_WIDTH - 1 - s : 0;
        idx      = IW'(shamt);
        sel      = p_right ? cur_right : (pop ? new_left : cur_left);
        bit_val  = in_range && sel[idx] && !mute;
    end

    // NOTE: all state here is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            b          <= '0;
            run        <= 1'b0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            dac_data   <= 1'b0;
            underrun   <= 1'b0;
            cur_left   <= '0;
            cur_right  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            in_ready   <= 1'b0;
`ifdef AUDIO_UNDERRUN_COUNT_EN
            underrun_count <= '0;
`endif
        end else begin
            run      <= enable;
            underrun <= pop && fifo_empty;
            if (enable) begin
                cnt  <= cnt_next;
                b    <= b_next;
                bclk <= (cnt_next >= CW'(BCLK_DIV / 2));
                if (load) begin
                    lrclk    <= (b_next >= BW'(SLOT_WIDTH));
                    dac_data <= bit_val;
                end
            end else begin
                cnt      <= '0;
                b        <= '0;
                bclk     <= 1'b0;
                lrclk    <= 1'b0;
                dac_data <= 1'b0;
            end
            if (pop) begin
                cur_left  <= new_left;
                cur_right <= new_right;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level <= level_next;
            in_ready   <= (level_next != LW'(FIFO_DEPTH));
`ifdef AUDIO_UNDERRUN_COUNT_EN
            if (pop && fifo_empty && (underrun_count != 16'hFFFF)) begin
                underrun_count <= underrun_count + 16'd1;
            end
`endif
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_left, in_right};
        end
    end

endmodule
